fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the multicycle N-RISC processor; sits directly upstream of the control unit.
- Holds the PC and fetches one instruction word per instruction from instruction memory over a req/ack handshake.
- Latches the word into an instruction register and splits it into opcode/rx/ry fields for the control unit and datapath.
- Updates the PC from the control unit's PCWrite/Branch outputs once the datapath reports the instruction complete.

Parameters:
- PC_W, 8, PC and instruction-memory address width in bits.
- RESET_PC, 0, PC value loaded on reset (PC_W bits).
- INSTR_W, 9, instruction width: opcode [8:6], rx [5:3], ry/imm [2:0]; fixed at 9.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, high for the whole S_FETCH state.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  INSTR_W  instruction word.
- exec_done  in  1  datapath finished the current instruction (1-cycle pulse).
- pc_write  in  1  PCWrite from control unit.
- branch  in  1  Branch from control unit.
- branch_cond  in  1  datapath compare result (taken when 1).
- instr_valid  out  1  one-cycle pulse: new instruction fields valid.
- opcode  out  3  ir[8:6], to control unit OPcode.
- rx  out  3  ir[5:3].
- ry  out  3  ir[2:0]; also branch offset (two's complement).
- pc  out  PC_W  current PC.
- instr_count  out  16  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): state=S_IDLE, pc=RESET_PC, ir=0 (so opcode/rx/ry=0), instr_valid=0, imem_req=0, instr_count=0. Reset wins over every other event, including an in-flight ack.
- FSM states: S_IDLE, S_FETCH, S_ISSUE, S_EXEC.
- S_IDLE: one cycle after reset release, then unconditional move to S_FETCH.
- S_FETCH:
  - imem_req=1 and imem_addr=pc (both Moore outputs).
  - On imem_ack: ir<=imem_rdata, go to S_ISSUE. Otherwise stay; no timeout.
- S_ISSUE: instr_valid=1 for exactly this cycle; go to S_EXEC.
- S_EXEC: wait for exec_done, then go to S_FETCH. pc_write, branch and branch_cond are sampled only in the exec_done cycle:
  - pc_write=0: pc unchanged; the same address is refetched.
  - pc_write=1, branch=1, branch_cond=1: pc <= pc + 1 + sext(ry).
  - pc_write=1, any other case: pc <= pc + 1.
  - exec_done outside S_EXEC is ignored.
- Arithmetic: PC is modulo 2^PC_W and wraps silently (max+1 -> 0). ry is sign-extended to PC_W bits (range -4..+3).
- opcode/rx/ry stay stable from S_ISSUE until the next imem_ack.
- Minimum throughput: 3 cycles per instruction (ack and exec_done each in the first possible cycle).
- imem_rdata is ignored when imem_ack=0.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on every exec_done accepted in S_EXEC and wraps at 16 bits; cleared by reset.
- Not defined: instr_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset/startup: RESET_PC=0, reset_n low 3 cycles, then high -> imem_req=0 during reset; imem_req=1 with imem_addr=0 on the 2nd cycle after release; instr_valid=0.
- Sequential fetch: ack in the same cycle with 9'b010_001_010; exec_done 2 cycles later with pc_write=1, branch=0 -> instr_valid pulses once, opcode=2, rx=1, ry=2; next imem_addr=1.
- Branch: pc=5, ir=9'b111_000_110 (offset -2), pc_write=1, branch=1 -> branch_cond=1 gives next address 4; branch_cond=0 gives 6.
- Hold/wrap: pc_write=0 at exec_done -> address 5 is refetched; PC_W=4, pc=15, sequential -> next address 0.
- Reset mid-fetch: reset_n low in S_FETCH while imem_ack=1 -> ir stays 0, imem_req drops immediately, pc=RESET_PC, no instr_valid pulse.
- FETCH_INSTR_COUNT_EN defined: 5 retired instructions -> instr_count=5; reset clears it to 0. Not defined: instr_count stays 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between the fetch stage (master) and
// instruction memory (slave): req/addr out, ack/rdata back.
interface fetch_stage_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// N-RISC multicycle instruction fetch stage: PC, instruction register, fetch FSM.
// Optional retired-instruction counter enabled by defining FETCH_INSTR_COUNT_EN.
module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INSTR_W  = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  fetch_stage_if.master    imem,
  input  logic             exec_done,
  input  logic             pc_write,
  input  logic             branch,
  input  logic             branch_cond,
  output logic             instr_valid,
  output logic [2:0]       opcode,
  output logic [2:0]       rx,
  output logic [2:0]       ry,
  output logic [PC_W-1:0]  pc,
  output logic [15:0]      instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [INSTR_W-1:0] ir;
  logic               exec_accept;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_branch;
  logic [PC_W-1:0]    ry_sext;

  // NOTE: state lives in always_ff with <= only; always_comb blocks use = so
  // every process sees the pre-edge value of a register, never a half-updated one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: if (imem.imem_ack) next_state = S_ISSUE;
      S_ISSUE: next_state = S_EXEC;
      S_EXEC:  if (exec_done) next_state = S_FETCH;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    case (state)
      S_FETCH: imem.imem_req = 1'b1;
      S_ISSUE: instr_valid   = 1'b1;
      default: ;
    endcase
  end

  assign imem.imem_addr = pc;

  // rdata is only meaningful with ack, and only the fetch state consumes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              ir <= '0;
    else if (state == S_FETCH && imem.imem_ack) ir <= imem.imem_rdata;
  end

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  // Branch offset is ry as a signed -4..+3 step relative to pc + 1.
  assign ry_sext     = {{(PC_W-3){ry[2]}}, ry};
  assign pc_inc      = pc + PC_W'(1);
  assign pc_branch   = pc_inc + ry_sext;
  assign exec_accept = (state == S_EXEC) && exec_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (exec_accept && pc_write) begin
      if (branch && branch_cond) pc <= pc_branch;
      else                       pc <= pc_inc;
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         count_q <= '0;
    else if (exec_accept) count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: an 8-bit-PC instance for the
// main scenarios and a 4-bit-PC instance starting at 15 for PC wrap.
module tb_fetch_stage;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Main instance (PC_W=8, RESET_PC=0)
  logic        exec_done, pc_write, branch, branch_cond;
  logic        instr_valid;
  logic [2:0]  opcode, rx, ry;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  fetch_stage_if #(.PC_W(8), .INSTR_W(9)) m_if ();

  fetch_stage #(.PC_W(8), .RESET_PC(8'd0), .INSTR_W(9)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem        (m_if.master),
    .exec_done   (exec_done),
    .pc_write    (pc_write),
    .branch      (branch),
    .branch_cond (branch_cond),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rx          (rx),
    .ry          (ry),
    .pc          (pc),
    .instr_count (instr_count)
  );

  // Wrap instance (PC_W=4, RESET_PC=15)
  logic        w_exec_done, w_pc_write, w_branch, w_branch_cond;
  logic        w_instr_valid;
  logic [2:0]  w_opcode, w_rx, w_ry;
  logic [3:0]  w_pc;
  logic [15:0] w_instr_count;

  fetch_stage_if #(.PC_W(4), .INSTR_W(9)) w_if ();

  fetch_stage #(.PC_W(4), .RESET_PC(4'hF), .INSTR_W(9)) dut_wrap (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem        (w_if.master),
    .exec_done   (w_exec_done),
    .pc_write    (w_pc_write),
    .branch      (w_branch),
    .branch_cond (w_branch_cond),
    .instr_valid (w_instr_valid),
    .opcode      (w_opcode),
    .rx          (w_rx),
    .ry          (w_ry),
    .pc          (w_pc),
    .instr_count (w_instr_count)
  );

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;

  function automatic logic [15:0] exp_ic();
`ifdef FETCH_INSTR_COUNT_EN
    return 16'(exp_count);
`else
    return 16'd0;
`endif
  endfunction

  // Drives one instruction through FETCH/ISSUE/EXEC at minimum latency.
  // Entered and left on a negedge with the main DUT in S_FETCH.
  task automatic run_instr(input logic [8:0] word, input logic pcw, input logic br,
                           input logic cond, output int valid_cycles);
    int n = 0;
    valid_cycles = 0;
    while (!m_if.imem_req && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!m_if.imem_req) begin
      checks++;
      errors++;
      $display("FAIL run_instr_req_timeout: imem_req=%0b after %0d cycles, need 1", m_if.imem_req, n);
    end
    m_if.imem_ack   = 1'b1;
    m_if.imem_rdata = word;
    @(negedge clock);
    m_if.imem_ack   = 1'b0;
    m_if.imem_rdata = ~word;
    if (instr_valid) valid_cycles++;
    @(negedge clock);
    if (instr_valid) valid_cycles++;
    exec_done   = 1'b1;
    pc_write    = pcw;
    branch      = br;
    branch_cond = cond;
    @(negedge clock);
    exec_done   = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_cond = 1'b0;
    if (instr_valid) valid_cycles++;
    exp_count++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (m_if.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b need 0", m_if.imem_req); end
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0d need 0", pc); end
    checks++; if ({opcode, rx, ry} !== 9'd0) begin errors++; $display("FAIL reset_ir: got %0h need 0", {opcode, rx, ry}); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b need 0", instr_valid); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d need 0", instr_count); end
    reset_n = 1'b1;
    #1;
    checks++; if (m_if.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b need 0", m_if.imem_req); end
    @(posedge clock);
    #1;
    checks++; if (m_if.imem_req !== 1'b1) begin errors++; $display("FAIL startup_req: got %0b need 1", m_if.imem_req); end
    checks++; if (m_if.imem_addr !== 8'd0) begin errors++; $display("FAIL startup_addr: got %0d need 0", m_if.imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL startup_valid: got %0b need 0", instr_valid); end
    @(negedge clock);
  endtask

  task automatic test_wrap();
    checks++; if (w_if.imem_addr !== 4'hF) begin errors++; $display("FAIL wrap_start_addr: got %0d need 15", w_if.imem_addr); end
    w_if.imem_ack   = 1'b1;
    w_if.imem_rdata = 9'b001_010_011;
    @(negedge clock);
    w_if.imem_ack = 1'b0;
    checks++; if (w_instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b need 1", w_instr_valid); end
    @(negedge clock);
    w_exec_done = 1'b1;
    w_pc_write  = 1'b1;
    @(negedge clock);
    w_exec_done = 1'b0;
    w_pc_write  = 1'b0;
    checks++; if (w_if.imem_addr !== 4'h0) begin errors++; $display("FAIL wrap_addr: got %0d need 0", w_if.imem_addr); end
    checks++; if (w_if.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %0b need 1", w_if.imem_req); end
  endtask

  task automatic test_sequential();
    int vc;
    run_instr(9'b010_001_010, 1'b1, 1'b0, 1'b0, vc);
    checks++; if (vc !== 1) begin errors++; $display("FAIL seq_valid_pulses: got %0d need 1", vc); end
    checks++; if (opcode !== 3'd2) begin errors++; $display("FAIL seq_opcode: got %0d need 2", opcode); end
    checks++; if (rx !== 3'd1) begin errors++; $display("FAIL seq_rx: got %0d need 1", rx); end
    checks++; if (ry !== 3'd2) begin errors++; $display("FAIL seq_ry: got %0d need 2", ry); end
    checks++; if (m_if.imem_addr !== 8'd1) begin errors++; $display("FAIL seq_next_addr: got %0d need 1", m_if.imem_addr); end
    checks++; if (m_if.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %0b need 1", m_if.imem_req); end
  endtask

  task automatic test_count();
    int vc;
    logic [8:0] words [4] = '{9'b000_011_111, 9'b100_100_100, 9'b011_001_000, 9'b101_110_001};
    for (int i = 0; i < 4; i++) run_instr(words[i], 1'b1, 1'b0, 1'b0, vc);
    checks++; if (pc !== 8'd5) begin errors++; $display("FAIL count_pc: got %0d need 5", pc); end
    checks++; if (instr_count !== exp_ic()) begin errors++; $display("FAIL count_five: got %0d need %0d", instr_count, exp_ic()); end
  endtask

  // exec_done outside S_EXEC and rdata without ack must both be ignored.
  task automatic test_ignore();
    m_if.imem_rdata = 9'h1FF;
    exec_done   = 1'b1;
    pc_write    = 1'b1;
    branch      = 1'b1;
    branch_cond = 1'b1;
    @(negedge clock);
    exec_done   = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_cond = 1'b0;
    checks++; if (pc !== 8'd5) begin errors++; $display("FAIL ignore_pc: got %0d need 5", pc); end
    checks++; if ({opcode, rx, ry} !== 9'b101_110_001) begin errors++; $display("FAIL ignore_ir: got %0b need 101110001", {opcode, rx, ry}); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid: got %0b need 0", instr_valid); end
    checks++; if (instr_count !== exp_ic()) begin errors++; $display("FAIL ignore_count: got %0d need %0d", instr_count, exp_ic()); end
  endtask

  task automatic test_hold();
    int vc;
    run_instr(9'b001_001_001, 1'b0, 1'b0, 1'b0, vc);
    checks++; if (m_if.imem_addr !== 8'd5) begin errors++; $display("FAIL hold_addr: got %0d need 5", m_if.imem_addr); end
  endtask

  task automatic test_branch();
    int vc;
    run_instr(9'b111_000_110, 1'b1, 1'b1, 1'b1, vc);
    checks++; if (m_if.imem_addr !== 8'd4) begin errors++; $display("FAIL branch_taken_addr: got %0d need 4", m_if.imem_addr); end
    checks++; if (ry !== 3'b110) begin errors++; $display("FAIL branch_ry: got %0d need 6", ry); end
    run_instr(9'b010_000_000, 1'b1, 1'b0, 1'b0, vc);
    run_instr(9'b111_000_110, 1'b1, 1'b1, 1'b0, vc);
    checks++; if (m_if.imem_addr !== 8'd6) begin errors++; $display("FAIL branch_not_taken_addr: got %0d need 6", m_if.imem_addr); end
    run_instr(9'b111_000_011, 1'b0, 1'b1, 1'b1, vc);
    checks++; if (m_if.imem_addr !== 8'd6) begin errors++; $display("FAIL branch_no_pcwrite_addr: got %0d need 6", m_if.imem_addr); end
    run_instr(9'b111_000_011, 1'b1, 1'b0, 1'b1, vc);
    checks++; if (m_if.imem_addr !== 8'd7) begin errors++; $display("FAIL branch_flag_low_addr: got %0d need 7", m_if.imem_addr); end
    run_instr(9'b111_000_011, 1'b1, 1'b1, 1'b1, vc);
    checks++; if (m_if.imem_addr !== 8'd11) begin errors++; $display("FAIL branch_fwd_addr: got %0d need 11", m_if.imem_addr); end
    checks++; if (instr_count !== exp_ic()) begin errors++; $display("FAIL branch_count: got %0d need %0d", instr_count, exp_ic()); end
  endtask

  task automatic test_reset_mid_fetch();
    int vc;
    m_if.imem_ack   = 1'b1;
    m_if.imem_rdata = 9'h1FF;
    reset_n         = 1'b0;
    #1;
    checks++; if (m_if.imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %0b need 0", m_if.imem_req); end
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL midrst_pc: got %0d need 0", pc); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d need 0", instr_count); end
    @(posedge clock);
    #1;
    checks++; if ({opcode, rx, ry} !== 9'd0) begin errors++; $display("FAIL midrst_ir: got %0h need 0", {opcode, rx, ry}); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b need 0", instr_valid); end
    @(negedge clock);
    m_if.imem_ack = 1'b0;
    reset_n       = 1'b1;
    exp_count     = 0;
    @(posedge clock);
    #1;
    checks++; if (instr_valid !== 1'b0 || m_if.imem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_restart: valid=%0b req=%0b need 0/1", instr_valid, m_if.imem_req);
    end
    @(negedge clock);
    run_instr(9'b110_101_100, 1'b1, 1'b0, 1'b0, vc);
    checks++; if (pc !== 8'd1 || opcode !== 3'd6) begin errors++; $display("FAIL midrst_refetch: pc=%0d opcode=%0d need 1/6", pc, opcode); end
    checks++; if (instr_count !== exp_ic()) begin errors++; $display("FAIL midrst_count_after: got %0d need %0d", instr_count, exp_ic()); end
  endtask

  initial begin
    exec_done = 1'b0; pc_write = 1'b0; branch = 1'b0; branch_cond = 1'b0;
    m_if.imem_ack = 1'b0; m_if.imem_rdata = '0;
    w_exec_done = 1'b0; w_pc_write = 1'b0; w_branch = 1'b0; w_branch_cond = 1'b0;
    w_if.imem_ack = 1'b0; w_if.imem_rdata = '0;

    test_reset();
    test_wrap();
    test_sequential();
    test_count();
    test_ignore();
    test_hold();
    test_branch();
    test_reset_mid_fetch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
